// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: req/ack data-memory port, byte lanes, load extension, registered WB.
// Optional define LSU_MISALIGN_TRAP_EN flags misaligned H/W accesses instead of forcing alignment.
module mem_stage_lsu #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ex_valid,
  output logic                  ex_ready,
  input  logic [DATA_WIDTH-1:0] ex_alu_result,
  input  logic [DATA_WIDTH-1:0] ex_store_data,
  input  logic                  ex_mem_read,
  input  logic                  ex_mem_write,
  input  logic [2:0]            ex_funct3,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic [DATA_WIDTH-1:0] dmem_wdata,
  output logic [3:0]            dmem_be,
  input  logic                  dmem_ack,
  input  logic [DATA_WIDTH-1:0] dmem_rdata,
  output logic                  wb_valid,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic [DATA_WIDTH-1:0] wb_data,
  output logic                  wb_misalign
);

  typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

  state_e                state_q, state_d;
  logic                  dmem_req_q, dmem_req_d, dmem_we_q, dmem_we_d;
  logic [ADDR_WIDTH-1:0] dmem_addr_q, dmem_addr_d;
  logic [DATA_WIDTH-1:0] dmem_wdata_q, dmem_wdata_d;
  logic [3:0]            dmem_be_q, dmem_be_d;
  logic                  wb_valid_q, wb_valid_d, wb_misalign_q, wb_misalign_d;
  logic [REG_ADDR_W-1:0] wb_rd_q, wb_rd_d;
  logic [DATA_WIDTH-1:0] wb_data_q, wb_data_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [1:0]            off_q, off_d;

  logic                  is_byte, is_half, mem_op, misalign_in;
  logic [1:0]            off_in;
  logic [3:0]            be_in;
  logic [DATA_WIDTH-1:0] wdata_in, load_ext;
  logic [7:0]            byte_sel;
  logic [15:0]           half_sel;

  // Request-side decode of the incoming EX op.
  always_comb begin
    is_byte = (ex_funct3 == 3'b000) || (ex_funct3 == 3'b100);
    is_half = (ex_funct3 == 3'b001) || (ex_funct3 == 3'b101);
    mem_op  = ex_mem_read || ex_mem_write;
    off_in  = ex_alu_result[1:0];
    if (is_byte) begin
      be_in    = 4'b0001 << off_in;
      wdata_in = {4{ex_store_data[7:0]}};
    end else if (is_half) begin
      be_in    = 4'b0011 << {off_in[1], 1'b0};
      wdata_in = {2{ex_store_data[15:0]}};
    end else begin
      be_in    = 4'hF;
      wdata_in = ex_store_data;
    end
`ifdef LSU_MISALIGN_TRAP_EN
    misalign_in = (is_half && off_in[0]) || (!is_byte && !is_half && (off_in != 2'b00));
`else
    misalign_in = 1'b0;
`endif
  end

  // Response-side lane select and extension using the latched op.
  always_comb begin
    byte_sel = dmem_rdata[{off_q, 3'b000} +: 8];
    half_sel = dmem_rdata[{off_q[1], 4'b0000} +: 16];
    unique case (funct3_q)
      3'b000:  load_ext = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
      3'b100:  load_ext = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
      3'b001:  load_ext = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
      3'b101:  load_ext = {{(DATA_WIDTH-16){1'b0}}, half_sel};
      default: load_ext = dmem_rdata;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    dmem_req_d    = dmem_req_q;
    dmem_we_d     = dmem_we_q;
    dmem_addr_d   = dmem_addr_q;
    dmem_wdata_d  = dmem_wdata_q;
    dmem_be_d     = dmem_be_q;
    wb_valid_d    = 1'b0;
    wb_misalign_d = 1'b0;
    wb_rd_d       = wb_rd_q;
    wb_data_d     = wb_data_q;
    funct3_d      = funct3_q;
    off_d         = off_q;
    unique case (state_q)
      StIdle: begin
        if (ex_valid) begin
          wb_rd_d = ex_rd;
          if (!mem_op || misalign_in) begin
            wb_valid_d    = 1'b1;
            wb_misalign_d = misalign_in;
            wb_data_d     = ex_alu_result;
            if (misalign_in) state_d = StResp;
          end else begin
            dmem_req_d   = 1'b1;
            dmem_we_d    = ex_mem_write && !ex_mem_read;
            dmem_addr_d  = {ex_alu_result[ADDR_WIDTH-1:2], 2'b00};
            dmem_wdata_d = wdata_in;
            dmem_be_d    = be_in;
            funct3_d     = ex_funct3;
            off_d        = off_in;
            state_d      = StReq;
          end
        end
      end
      StReq: begin
        if (dmem_ack) begin
          dmem_req_d = 1'b0;
          dmem_we_d  = 1'b0;
          dmem_be_d  = 4'h0;
          wb_valid_d = 1'b1;
          wb_data_d  = dmem_we_q ? '0 : load_ext;
          state_d    = StResp;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      dmem_req_q    <= 1'b0;
      dmem_we_q     <= 1'b0;
      dmem_addr_q   <= '0;
      dmem_wdata_q  <= '0;
      dmem_be_q     <= 4'h0;
      wb_valid_q    <= 1'b0;
      wb_misalign_q <= 1'b0;
      wb_rd_q       <= '0;
      wb_data_q     <= '0;
      funct3_q      <= 3'b000;
      off_q         <= 2'b00;
    end else begin
      state_q       <= state_d;
      dmem_req_q    <= dmem_req_d;
      dmem_we_q     <= dmem_we_d;
      dmem_addr_q   <= dmem_addr_d;
      dmem_wdata_q  <= dmem_wdata_d;
      dmem_be_q     <= dmem_be_d;
      wb_valid_q    <= wb_valid_d;
      wb_misalign_q <= wb_misalign_d;
      wb_rd_q       <= wb_rd_d;
      wb_data_q     <= wb_data_d;
      funct3_q      <= funct3_d;
      off_q         <= off_d;
    end
  end

  assign ex_ready    = (state_q == StIdle);
  assign dmem_req    = dmem_req_q;
  assign dmem_we     = dmem_we_q;
  assign dmem_addr   = dmem_addr_q;
  assign dmem_wdata  = dmem_wdata_q;
  assign dmem_be     = dmem_be_q;
  assign wb_valid    = wb_valid_q;
  assign wb_rd       = wb_rd_q;
  assign wb_data     = wb_data_q;
  assign wb_misalign = wb_misalign_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Randomized bench for mem_stage_lsu against a cycle-indexed expectation model.
module tb_mem_stage_lsu;

  logic        clk = 1'b0, reset = 1'b1;
  logic        ex_valid = 1'b0, ex_ready;
  logic [31:0] ex_alu_result = '0, ex_store_data = '0;
  logic        ex_mem_read = 1'b0, ex_mem_write = 1'b0;
  logic [2:0]  ex_funct3 = '0;
  logic [4:0]  ex_rd = '0;
  logic        dmem_req, dmem_we, dmem_ack = 1'b0;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata = '0;
  logic [3:0]  dmem_be;
  logic        wb_valid, wb_misalign;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  mem_stage_lsu dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_funct3(ex_funct3),
    .ex_rd(ex_rd), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .wb_misalign(wb_misalign)
  );

  always #5 clk = ~clk;

  typedef struct {logic [4:0] rd; logic [31:0] data; bit chk_data; bit mis;} wb_t;
  typedef struct {logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; bit we;} req_t;

  wb_t  exp_wb[int];
  req_t exp_req[int];
  bit   exp_busy[int];
  int   cyc = 0;
  int   n_tests = 0, n_fail = 0;
  bit   chk_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endfunction

  // Access size in bytes; undefined funct3 behaves as a word.
  function automatic int m_size(logic [2:0] f3);
    if (f3 == 3'b000 || f3 == 3'b100) return 1;
    if (f3 == 3'b001 || f3 == 3'b101) return 2;
    return 4;
  endfunction

  function automatic logic [3:0] m_be(logic [2:0] f3, logic [31:0] a);
    int sz = m_size(f3);
    if (sz == 1) return 4'(1 << (a % 4));
    if (sz == 2) return 4'(3 << (a & 2));
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wdata(logic [2:0] f3, logic [31:0] d);
    int sz = m_size(f3);
    if (sz == 1) return (d & 32'hFF) * 32'h0101_0101;
    if (sz == 2) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] m_load(logic [2:0] f3, logic [31:0] a, logic [31:0] r);
    int sz = m_size(f3);
    int sh;
    logic [31:0] mask, v;
    if (sz == 4) return r;
    sh   = (sz == 1) ? 8 * int'(a % 4) : 16 * int'((a / 2) % 2);
    mask = (sz == 1) ? 32'hFF : 32'hFFFF;
    v    = (r >> sh) & mask;
    if (f3[2] == 1'b0 && (v & ((mask + 1) >> 1)) != 0) v = v | ~mask;
    return v;
  endfunction

  function automatic bit m_mis(logic [2:0] f3, logic [31:0] a);
`ifdef LSU_MISALIGN_TRAP_EN
    return (m_size(f3) == 2 && a % 2 != 0) || (m_size(f3) == 4 && a % 4 != 0);
`else
    return 1'b0;
`endif
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("ex_ready", 32'(ex_ready), 32'(!exp_busy.exists(cyc)));
      check("wb_valid", 32'(wb_valid), 32'(exp_wb.exists(cyc)));
      if (exp_wb.exists(cyc)) begin
        check("wb_rd", 32'(wb_rd), 32'(exp_wb[cyc].rd));
        if (exp_wb[cyc].chk_data) check("wb_data", wb_data, exp_wb[cyc].data);
        check("wb_misalign", 32'(wb_misalign), 32'(exp_wb[cyc].mis));
      end
      check("dmem_req", 32'(dmem_req), 32'(exp_req.exists(cyc)));
      if (exp_req.exists(cyc)) begin
        check("dmem_addr", dmem_addr, exp_req[cyc].addr);
        check("dmem_be", 32'(dmem_be), 32'(exp_req[cyc].be));
        check("dmem_wdata", dmem_wdata, exp_req[cyc].wdata);
        check("dmem_we", 32'(dmem_we), 32'(exp_req[cyc].we));
      end
    end
  end

  task automatic junk_ex();
    ex_valid      = 1'($urandom);
    ex_alu_result = $urandom;
    ex_store_data = $urandom;
    {ex_mem_read, ex_mem_write} = 2'($urandom);
    ex_funct3     = 3'($urandom);
    ex_rd         = 5'($urandom);
  endtask

  // Called just after a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic do_op(input bit rd_en, input bit wr_en, input logic [2:0] f3,
                       input logic [31:0] alu, input logic [31:0] sd, input logic [4:0] rd,
                       input logic [31:0] rdata, input int delay, input bit lit,
                       input logic [31:0] l_addr, input logic [3:0] l_be,
                       input logic [31:0] l_wdata, input logic [31:0] l_wb);
    int k = cyc;
    ex_valid = 1'b1; ex_alu_result = alu; ex_store_data = sd;
    ex_mem_read = rd_en; ex_mem_write = wr_en; ex_funct3 = f3; ex_rd = rd;
    dmem_ack = 1'($urandom); dmem_rdata = $urandom;
    if (!(rd_en || wr_en)) begin
      exp_wb[k+1] = '{rd, alu, 1'b1, 1'b0};
      @(negedge clk);
      if (lit) check("lit_alu_wb", wb_data, l_wb);
      return;
    end
    if (m_mis(f3, alu)) begin
      exp_wb[k+1] = '{rd, alu, 1'b1, 1'b1};
      exp_busy[k+1] = 1'b1;
      @(negedge clk);
      junk_ex(); dmem_ack = 1'($urandom);
      @(negedge clk);
      return;
    end
    for (int j = 1; j <= delay + 1; j++) begin
      exp_req[k+j]  = '{{alu[31:2], 2'b00}, m_be(f3, alu), m_wdata(f3, sd), !rd_en};
      exp_busy[k+j] = 1'b1;
    end
    exp_wb[k+delay+2]   = '{rd, m_load(f3, alu, rdata), rd_en, 1'b0};
    exp_busy[k+delay+2] = 1'b1;
    @(negedge clk);
    if (lit) begin
      check("lit_addr", dmem_addr, l_addr);
      check("lit_be", 32'(dmem_be), 32'(l_be));
      if (wr_en) check("lit_wdata", dmem_wdata, l_wdata);
    end
    for (int j = 0; j <= delay; j++) begin
      junk_ex();
      dmem_ack   = (j == delay);
      dmem_rdata = (j == delay) ? rdata : $urandom;
      @(negedge clk);
    end
    if (lit && rd_en) check("lit_load_wb", wb_data, l_wb);
    junk_ex(); dmem_ack = 1'($urandom); dmem_rdata = $urandom;
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_req", 32'(dmem_req), 0);
    check("rst_we", 32'(dmem_we), 0);
    check("rst_be", 32'(dmem_be), 0);
    check("rst_addr", dmem_addr, 0);
    check("rst_wdata", dmem_wdata, 0);
    check("rst_wb_valid", 32'(wb_valid), 0);
    check("rst_wb_rd", 32'(wb_rd), 0);
    check("rst_wb_data", wb_data, 0);
    check("rst_misalign", 32'(wb_misalign), 0);
    check("rst_ready", 32'(ex_ready), 1);
    reset = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);

    do_op(0, 0, 3'b000, 32'h0000_1234, 0, 5, 0, 0, 1, 0, 0, 0, 32'h1234);
    do_op(0, 1, 3'b000, 32'h103, 32'hAB, 7, 0, 1, 1, 32'h100, 4'b1000, 32'hABAB_ABAB, 0);
    do_op(1, 0, 3'b000, 32'h102, 0, 3, 32'h0080_0000, 0, 1, 32'h100, 4'b0100, 0,
          32'hFFFF_FF80);
    do_op(1, 0, 3'b100, 32'h102, 0, 3, 32'h0080_0000, 2, 1, 32'h100, 4'b0100, 0,
          32'h0000_0080);
    do_op(1, 0, 3'b001, 32'h202, 0, 9, 32'h8001_0000, 1, 1, 32'h200, 4'b1100, 0,
          32'hFFFF_8001);
`ifdef LSU_MISALIGN_TRAP_EN
    do_op(1, 0, 3'b010, 32'h101, 0, 4, 32'h1111_2222, 0, 0, 0, 0, 0, 0);
`else
    do_op(1, 0, 3'b010, 32'h101, 0, 4, 32'h1111_2222, 0, 1, 32'h100, 4'hF, 0, 32'h1111_2222);
`endif

    for (int i = 0; i < 400; i++) begin
      int kind = int'($urandom_range(0, 4));
      if (kind == 4) begin
        ex_valid = 1'b0; dmem_ack = 1'($urandom); dmem_rdata = $urandom;
        @(negedge clk);
      end else begin
        do_op(kind == 1 || kind == 3, kind == 2 || kind == 3, 3'($urandom), $urandom,
              $urandom, 5'($urandom), $urandom, int'($urandom_range(0, 3)), 0, 0, 0, 0, 0);
      end
    end

    ex_valid = 1'b0; dmem_ack = 1'b0;
    @(negedge clk);
    chk_en = 1'b0;
    // Reset while a load is waiting for its ack.
    ex_valid = 1'b1; ex_mem_read = 1'b1; ex_mem_write = 1'b0;
    ex_funct3 = 3'b010; ex_alu_result = 32'h400; ex_rd = 3;
    @(negedge clk);
    ex_valid = 1'b0;
    check("mid_req_before_rst", 32'(dmem_req), 1);
    #2 reset = 1'b1;
    #1 check("mid_req_async_drop", 32'(dmem_req), 0);
    check("mid_ready_in_rst", 32'(ex_ready), 1);
    dmem_ack = 1'b1;
    @(negedge clk);
    check("mid_wb_in_rst", 32'(wb_valid), 0);
    reset = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      check("mid_no_wb", 32'(wb_valid), 0);
      check("mid_ready", 32'(ex_ready), 1);
      check("mid_no_req", 32'(dmem_req), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
